// File: rtl/inner_fn_pkg.sv
// Shared definitions for the inner-function accelerator: FSM encoding,
// default pipeline latency and float constants.
package inner_fn_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Adder, multiplier and divider stages of the pipeline wrapper.
  localparam int INNER_FN_LATENCY = 3*2 + 5*2 + 9;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/inner_fn_timeout.sv
// Reloadable watchdog: counts enabled cycles while run is high and flags
// expired once the count passes LIMIT. Saturates so expired stays asserted.
module inner_fn_timeout #(
  parameter int LIMIT = 29
) (
  input  logic clock,
  input  logic aclr,
  input  logic clk_en,
  input  logic clear,
  input  logic reload,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 2);

  logic [W-1:0] cnt;

  assign expired = cnt > W'(LIMIT);

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      cnt <= '0;
    end else if (clk_en) begin
      if (clear || reload)       cnt <= '0;
      else if (run && !expired)  cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/inner_fn_batch_ctrl.sv
// Batch sequencer: streams count operands from the source RAM into the
// fixed-latency inner-function pipeline and writes results back in order.
module inner_fn_batch_ctrl
  import inner_fn_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int PIPE_LATENCY  = INNER_FN_LATENCY,
  parameter int TIMEOUT_SLACK = 4
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [ADDR_W-1:0] cmd_dst_base,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              busy,
  output logic              batch_done,
  output logic              err,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  output logic              fn_start,
  output logic [31:0]       fn_dataa,
  output logic              fn_aclr,
  input  logic [31:0]       fn_result,
  input  logic              fn_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [31:0]       wr_data
);

  localparam int CW = ADDR_W + 1;

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [CW-1:0]     count, issue_idx, wr_idx, wr_idx_nx, outstanding;
  logic              rvld;
  logic              accept, wr_fire, spurious, expired, timeout;

  assign accept    = clk_en & cmd_start & (state == ST_IDLE);
  assign busy      = (state == ST_ISSUE) | (state == ST_DRAIN);
  assign batch_done = (state == ST_FINISH);
  assign fn_aclr   = ~aclr;

  assign rd_en     = clk_en & (state == ST_ISSUE);
  assign rd_addr   = src_base + issue_idx[ADDR_W-1:0];
  assign fn_start  = clk_en & rvld;
  assign fn_dataa  = fn_start ? rd_data : FP_ZERO;

  // A done with nothing in flight is never written; it only raises err.
  assign spurious  = clk_en & fn_done & (outstanding == '0);
  assign wr_fire   = clk_en & fn_done & (outstanding != '0);
  assign wr_en     = wr_fire;
  assign wr_addr   = wr_fire ? dst_base + wr_idx[ADDR_W-1:0] : '0;
  assign wr_data   = wr_fire ? fn_result : FP_ZERO;
  assign wr_idx_nx = wr_idx + CW'(wr_fire);

  assign timeout   = expired & busy;

  inner_fn_timeout #(
    .LIMIT(PIPE_LATENCY + TIMEOUT_SLACK)
  ) u_timeout (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .clear  (accept | timeout),
    .reload (fn_start | wr_fire),
    .run    (outstanding != '0),
    .expired(expired)
  );

  // A zero-length batch passes through DRAIN, whose wr_idx==count test is
  // already satisfied, so busy is visible for one cycle before completion.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = (cmd_count == '0) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE:  if (timeout) state_nx = ST_FINISH;
                 else if (issue_idx == count - CW'(1)) state_nx = ST_DRAIN;
      ST_DRAIN:  if (timeout || wr_idx_nx == count) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state       <= ST_IDLE;
      src_base    <= '0;
      dst_base    <= '0;
      count       <= '0;
      issue_idx   <= '0;
      wr_idx      <= '0;
      outstanding <= '0;
      rvld        <= 1'b0;
      err         <= 1'b0;
    end else if (clk_en) begin
      state <= state_nx;
      rvld  <= (state == ST_ISSUE) & ~timeout;
      err   <= (err & ~accept) | spurious | timeout;
      if (accept) begin
        src_base  <= cmd_src_base;
        dst_base  <= cmd_dst_base;
        count     <= cmd_count;
        issue_idx <= '0;
        wr_idx    <= '0;
      end else begin
        if (state == ST_ISSUE) issue_idx <= issue_idx + CW'(1);
        wr_idx <= wr_idx_nx;
      end
      // An abandoned batch forgets its in-flight work, so a late done is spurious.
      if (timeout)                   outstanding <= '0;
      else if (fn_start && !wr_fire) outstanding <= outstanding + CW'(1);
      else if (!fn_start && wr_fire) outstanding <= outstanding - CW'(1);
    end
  end

endmodule

// File: tb/tb_inner_fn_batch_ctrl.sv
// Bench for inner_fn_batch_ctrl: RAM and pipeline stubs, a per-cycle
// schedule model derived from batch parameters, and directed corner cases.
module tb_inner_fn_batch_ctrl;

  localparam int AW = 10;
  localparam int L  = 25;
  localparam int S  = 4;

  logic          clock = 1'b0;
  logic          aclr = 1'b0, clk_en = 1'b1, cmd_start = 1'b0;
  logic [AW-1:0] cmd_src_base = '0, cmd_dst_base = '0;
  logic [AW:0]   cmd_count = '0;
  logic          busy, batch_done, err, rd_en, fn_start, fn_aclr, fn_done, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data = '0, fn_dataa, fn_result, wr_data;

  inner_fn_batch_ctrl #(.ADDR_W(AW), .PIPE_LATENCY(L), .TIMEOUT_SLACK(S)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .cmd_start(cmd_start),
    .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base), .cmd_count(cmd_count),
    .busy(busy), .batch_done(batch_done), .err(err),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .fn_start(fn_start), .fn_dataa(fn_dataa), .fn_aclr(fn_aclr),
    .fn_result(fn_result), .fn_done(fn_done),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Source and destination RAMs
  logic [31:0] src_mem [1024];
  logic [31:0] dst_mem [1024];
  always @(posedge clock) if (rd_en) rd_data <= src_mem[rd_addr];
  always @(posedge clock) if (wr_en) dst_mem[wr_addr] <= wr_data;

  // Pipeline stub: returns dataa+1 after L cycles, optionally dropping one result
  logic          inj = 1'b0;
  logic [L-1:0]  pv;
  logic [31:0]   pd [L];
  int            start_n;
  int            drop_at = -1;
  assign fn_done   = pv[L-1] | inj;
  assign fn_result = pd[L-1];

  always @(posedge clock or posedge fn_aclr) begin
    if (fn_aclr) begin
      pv <= '0;
      start_n <= 0;
      for (int i = 0; i < L; i++) pd[i] <= '0;
    end else begin
      pv <= {pv[L-2:0], fn_start && (start_n + 1 != drop_at)};
      pd[0] <= fn_dataa + 32'd1;
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
      if (fn_start) start_n <= start_n + 1;
    end
  end

  // Event monitor
  int wr_cnt = 0, last_wr_cyc = -1, done_cyc = -1;
  always @(posedge clock) begin
    if (wr_en) begin wr_cnt++; last_wr_cyc = cyc; end
    if (batch_done) done_cyc = cyc;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Schedule model: expected strobes keyed by cycle number
  logic [AW-1:0]    exp_rd [int];
  logic [31:0]      exp_st [int];
  logic [AW+31:0]   exp_wr [int];
  int  t_acc = 0, t_done = 0, frz0 = 0, frz_len = 0;
  bit  model_on = 0;

  function automatic bit en_at(int c);
    return !(frz_len > 0 && c >= frz0 && c < frz0 + frz_len);
  endfunction

  task automatic plan(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
    int c, s, last;
    logic [AW-1:0] a, w;
    exp_rd.delete(); exp_st.delete(); exp_wr.delete();
    c = t_acc + 1;
    last = 0;
    for (int k = 0; k < n; k++) begin
      while (!en_at(c)) c++;
      a = src + AW'(k);
      w = dst + AW'(k);
      exp_rd[c] = a;
      s = c + 1;
      while (!en_at(s)) s++;
      exp_st[s] = src_mem[a];
      exp_wr[s + L] = {w, src_mem[a] + 32'd1};
      last = s + L;
      c++;
    end
    t_done = (n == 0) ? t_acc + 2 : last + 1;
  endtask

  task automatic compare();
    bit e;
    e = exp_rd.exists(cyc);
    chk("rd_en", rd_en, e);
    if (e) chk("rd_addr", rd_addr, exp_rd[cyc]);
    e = exp_st.exists(cyc);
    chk("fn_start", fn_start, e);
    if (e) chk("fn_dataa", fn_dataa, exp_st[cyc]);
    e = exp_wr.exists(cyc);
    chk("wr_en", wr_en, e);
    if (e) chk("wr_addr_data", {wr_addr, wr_data}, exp_wr[cyc]);
    chk("busy", busy, cyc > t_acc && cyc < t_done);
    chk("batch_done", batch_done, cyc == t_done);
    chk("err", err, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cmd_start = 1'b0;
    clk_en = en_at(cyc);
    @(negedge clock);
    if (model_on) compare();
  endtask

  task automatic run_batch(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int n, input int fz_off, input int fz_len);
    t_acc = cyc;
    frz0 = t_acc + 1 + fz_off;
    frz_len = fz_len;
    plan(src, dst, n);
    cmd_src_base = src;
    cmd_dst_base = dst;
    cmd_count = (AW+1)'(n);
    cmd_start = 1'b1;
    model_on = 1;
    repeat (t_done + 1 - t_acc) step();
    model_on = 0;
    frz_len = 0;
  endtask

  task automatic start_raw(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
    t_acc = cyc;
    cmd_src_base = src;
    cmd_dst_base = dst;
    cmd_count = (AW+1)'(n);
    cmd_start = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_batch_done", batch_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_fn_start", fn_start, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_addr", rd_addr, '0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_fn_dataa", fn_dataa, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_fn_aclr", fn_aclr, 1'b1);
  endtask

  initial begin
    int w0, gap, n;
    bit seen;
    logic [AW-1:0] sb, db;

    for (int i = 0; i < 1024; i++) src_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) src_mem[16 + i] = 32'h4300_0000 + i;

    // Reset state
    repeat (3) @(negedge clock);
    chk_reset();
    aclr = 1'b1;
    step();
    chk("fn_aclr_released", fn_aclr, 1'b0);
    step();

    // Directed count=4
    run_batch(10'h010, 10'h200, 4, 0, 0);
    chk("c4_latency", done_cyc - t_acc, 31);
    for (int i = 0; i < 4; i++) chk("c4_dst", dst_mem[10'h200 + i], 32'h4300_0001 + i);

    // Zero-length batch
    w0 = wr_cnt;
    run_batch(10'h055, 10'h066, 0, 0, 0);
    chk("c0_latency", done_cyc - t_acc, 2);
    chk("c0_no_writes", wr_cnt - w0, 0);

    // Address wrap on both sides
    run_batch(10'h3FE, 10'h3FF, 3, 0, 0);
    chk("wrap_dst0", dst_mem[10'h3FF], src_mem[10'h3FE] + 32'd1);
    chk("wrap_dst1", dst_mem[10'h000], src_mem[10'h3FF] + 32'd1);
    chk("wrap_dst2", dst_mem[10'h001], src_mem[10'h000] + 32'd1);

    // clk_en low 5 cycles mid-issue
    run_batch(10'h100, 10'h180, 8, 3, 5);
    chk("frz_latency", done_cyc - t_acc, 2 + 8 + L + 5);
    for (int i = 0; i < 8; i++) chk("frz_dst", dst_mem[10'h180 + i], src_mem[10'h100 + i] + 32'd1);

    // Randomized batches
    for (int b = 0; b < 10; b++) begin
      n  = (b == 7) ? 0 : int'($urandom_range(1, 60));
      sb = AW'($urandom);
      db = AW'($urandom);
      if (n >= 4 && b[0]) run_batch(sb, db, n, int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
      else                run_batch(sb, db, n, 0, 0);
      step();
    end

    // Full-size batch
    run_batch(10'h155, 10'h2AA, 1024, 0, 0);
    chk("full_latency", done_cyc - t_acc, 2 + 1024 + L);
    chk("full_first", dst_mem[10'h2AA], src_mem[10'h155] + 32'd1);
    chk("full_last", dst_mem[10'h2A9], src_mem[10'h154] + 32'd1);

    // Dropped second result: timeout, abandon, err
    w0 = wr_cnt;
    drop_at = start_n + 2;
    start_raw(10'h020, 10'h300, 4);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = (done_cyc > t_acc);
    end
    drop_at = -1;
    chk("drop_done_seen", seen, 1'b1);
    chk("drop_err", err, 1'b1);
    chk("drop_writes", wr_cnt - w0, 3);
    gap = done_cyc - last_wr_cyc;
    chk("drop_timeout_window", (gap > L + S) && (gap <= L + S + 4), 1'b1);
    repeat (3) step();
    chk("drop_err_sticky", err, 1'b1);
    run_batch(10'h030, 10'h310, 1, 0, 0);

    // Spurious done while idle
    w0 = wr_cnt;
    inj = 1'b1;
    #1;
    chk("spur_no_wr", wr_en, 1'b0);
    @(posedge clock);
    #1;
    inj = 1'b0;
    chk("spur_err", err, 1'b1);
    @(negedge clock);
    chk("spur_wr_cnt", wr_cnt - w0, 0);
    run_batch(10'h040, 10'h320, 2, 0, 0);

    // Reset during DRAIN
    start_raw(10'h050, 10'h330, 6);
    repeat (20) step();
    chk("pre_rst_busy", busy, 1'b1);
    aclr = 1'b0;
    #1;
    chk_reset();
    repeat (2) step();
    aclr = 1'b1;
    w0 = wr_cnt;
    repeat (40) step();
    chk("post_rst_no_wr", wr_cnt - w0, 0);
    run_batch(10'h060, 10'h340, 2, 0, 0);
    chk("post_rst_dst", dst_mem[10'h341], src_mem[10'h061] + 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
